// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch stage: reset/bubble defaults,
// next-PC select encoding, per-cycle fetch state and word-alignment helper.
// No ports; imported by the fetch-stage top and its sub-modules.
package mips_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    PCSEL_SEQ  = 2'd0,
    PCSEL_BR   = 2'd1,
    PCSEL_JMP  = 2'd2,
    PCSEL_HOLD = 2'd3
  } pcsel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALLED  = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Bundle of all fetch-stage signals exchanged with the PC adder, instruction
// memory, hazard unit, branch/jump resolution and the decode stage.
// master: the fetch stage itself; slave: the surrounding pipeline/environment.
interface pc_fetch_stage_if;

  logic [31:0] PCAddResult;
  logic [31:0] Instruction;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;

  logic [31:0] PCResult;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        AlignErr;
  logic [31:0] FetchCount;

  modport master (
    input  PCAddResult, Instruction, Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
    output PCResult, IFID_Instruction, IFID_PCPlus4, IFID_Valid, AlignErr, FetchCount
  );

  modport slave (
    output PCAddResult, Instruction, Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
    input  PCResult, IFID_Instruction, IFID_PCPlus4, IFID_Valid, AlignErr, FetchCount
  );

endinterface

// File: rtl/pc_fetch_stage_if_id_register.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit for decode.
// Ports: hold_i freezes all fields, flush_i loads a bubble (NOP, PC+4=0, invalid);
//        instr_i/pc_plus4_i are loaded otherwise; *_o are the registered values.
module if_id_register
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Hold outranks flush: a redirect seen during a stall is re-presented later.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!hold_i) begin
      if (flush_i) begin
        instr_d = NOP_WORD;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_i;
        pc4_d   = pc_plus4_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select (stall > jump > branch > PC+4),
// wrong-path squash on redirect, sticky misaligned-target flag, fetch counter.
// Ports: Clk/Reset plain; everything else via pc_fetch_stage_if.master.
module pc_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic              Clk,
  input  logic              Reset,
  pc_fetch_stage_if.master  fif
);

  fetch_state_e fetch_state;
  pcsel_e       pc_sel;
  logic [31:0]  redir_tgt;

  logic [31:0]  pc_q, pc_d;
  logic         align_err_q, align_err_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  // Stage state is purely a decode of this cycle's control inputs.
  always_comb begin
    fetch_state = ST_RUN;
    pc_sel      = PCSEL_SEQ;
    redir_tgt   = 32'h0;
    if (fif.Stall) begin
      fetch_state = ST_STALLED;
      pc_sel      = PCSEL_HOLD;
    end else if (fif.Jump) begin
      fetch_state = ST_REDIRECT;
      pc_sel      = PCSEL_JMP;
      redir_tgt   = fif.JumpTarget;
    end else if (fif.BranchTaken) begin
      fetch_state = ST_REDIRECT;
      pc_sel      = PCSEL_BR;
      redir_tgt   = fif.BranchTarget;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    align_err_d   = align_err_q;
    fetch_count_d = fetch_count_q;
    case (pc_sel)
      PCSEL_SEQ:  pc_d = fif.PCAddResult;
      PCSEL_BR,
      PCSEL_JMP:  pc_d = word_align(redir_tgt);
      default:    pc_d = pc_q;
    endcase
    // Misaligned target is flagged but the PC is still forced to a word boundary.
    if (fetch_state == ST_REDIRECT && redir_tgt[1:0] != 2'b00) begin
      align_err_d = 1'b1;
    end
    // Only real instructions entering IF/ID are counted; wraps naturally.
    if (fetch_state == ST_RUN) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q          <= RESET_PC;
      align_err_q   <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      align_err_q   <= align_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .Clk        (Clk),
    .Reset      (Reset),
    .hold_i     (fetch_state == ST_STALLED),
    .flush_i    (fetch_state == ST_REDIRECT),
    .instr_i    (fif.Instruction),
    .pc_plus4_i (fif.PCAddResult),
    .instr_o    (fif.IFID_Instruction),
    .pc_plus4_o (fif.IFID_PCPlus4),
    .valid_o    (fif.IFID_Valid)
  );

  assign fif.PCResult   = pc_q;
  assign fif.AlignErr   = align_err_q;
  assign fif.FetchCount = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pc_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model of architecturally visible state.
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_align;

  pc_fetch_stage_if fif();

  pc_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_align = 1'b0;
  endtask

  // Adder is modelled: PCAddResult is always model PC + 4.
  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
    fif.Stall        = st;
    fif.BranchTaken  = br;
    fif.BranchTarget = bt;
    fif.Jump         = jp;
    fif.JumpTarget   = jt;
    fif.PCAddResult  = m_pc + 32'd4;
    fif.Instruction  = $urandom;
  endtask

  task automatic tick();
    logic [31:0] tgt;
    @(posedge clk);
    if (!fif.Stall) begin
      if (fif.Jump || fif.BranchTaken) begin
        tgt = fif.Jump ? fif.JumpTarget : fif.BranchTarget;
        if (tgt % 4 != 0) m_align = 1'b1;
        m_pc = tgt - (tgt % 4);
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = fif.Instruction;
        m_pc4   = fif.PCAddResult;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 1;
        m_pc    = fif.PCAddResult;
      end
    end
    #1;
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    drive(0, 0, 0, 0, 0);
    #3;
    n_tests++; if (fif.PCResult !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", fif.PCResult); end
    n_tests++; if (fif.IFID_Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", fif.IFID_Instruction); end
    n_tests++; if (fif.IFID_PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", fif.IFID_PCPlus4); end
    n_tests++; if (fif.IFID_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", fif.IFID_Valid); end
    n_tests++; if (fif.AlignErr !== 1'b0) begin n_fail++; $display("FAIL reset_align got %b want 0", fif.AlignErr); end
    n_tests++; if (fif.FetchCount !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", fif.FetchCount); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    drive(0, 0, 0, 0, 0);
    fif.Instruction = 32'h2008_0005;
    tick();
    n_tests++; if (fif.PCResult !== 32'h4) begin n_fail++; $display("FAIL first_pc got %h want 4", fif.PCResult); end
    n_tests++; if (fif.IFID_Instruction !== 32'h2008_0005) begin n_fail++; $display("FAIL first_instr got %h want 20080005", fif.IFID_Instruction); end
    n_tests++; if (fif.IFID_PCPlus4 !== 32'h4) begin n_fail++; $display("FAIL first_pc4 got %h want 4", fif.IFID_PCPlus4); end
    n_tests++; if (fif.IFID_Valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", fif.IFID_Valid); end
    n_tests++; if (fif.FetchCount !== 32'h1) begin n_fail++; $display("FAIL first_count got %h want 1", fif.FetchCount); end
    // Async reset mid-run and mid-stall, checked before the next edge.
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0); tick(); end
    drive(1, 1, 32'h80, 1, 32'h100);
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (fif.PCResult !== 32'h0 || fif.IFID_Valid !== 1'b0 || fif.FetchCount !== 32'h0 ||
                   fif.IFID_Instruction !== 32'h0 || fif.IFID_PCPlus4 !== 32'h0 || fif.AlignErr !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got pc=%h v=%b cnt=%h ins=%h pc4=%h ae=%b want all zero",
               fif.PCResult, fif.IFID_Valid, fif.FetchCount, fif.IFID_Instruction, fif.IFID_PCPlus4, fif.AlignErr);
    end
    rst = 1'b0;
  endtask

  task automatic test_stall();
    hard_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 0); tick(); end
    n_tests++; if (fif.PCResult !== 32'h10) begin n_fail++; $display("FAIL stall_setup_pc got %h want 10", fif.PCResult); end
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 1, 32'h40, i == 2, 32'h200);
      tick();
      n_tests++;
      if (fif.PCResult !== 32'h10 || fif.IFID_Instruction !== m_instr || fif.IFID_PCPlus4 !== 32'h10 ||
          fif.IFID_Valid !== 1'b1 || fif.FetchCount !== 32'd4) begin
        n_fail++;
        $display("FAIL stall_hold got pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=10 ins=%h pc4=10 v=1 cnt=4",
                 fif.PCResult, fif.IFID_Instruction, fif.IFID_PCPlus4, fif.IFID_Valid, fif.FetchCount, m_instr);
      end
    end
    drive(0, 0, 0, 0, 0); tick();
    n_tests++; if (fif.PCResult !== 32'h14) begin n_fail++; $display("FAIL stall_release_pc got %h want 14", fif.PCResult); end
  endtask

  task automatic test_branch();
    hard_reset();
    for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 0, 0); tick(); end
    drive(0, 1, 32'h40, 0, 0); tick();
    n_tests++; if (fif.PCResult !== 32'h40) begin n_fail++; $display("FAIL br_pc got %h want 40", fif.PCResult); end
    n_tests++; if (fif.IFID_Valid !== 1'b0 || fif.IFID_Instruction !== 32'h0 || fif.IFID_PCPlus4 !== 32'h0) begin
      n_fail++; $display("FAIL br_bubble got v=%b ins=%h pc4=%h want 0 0 0", fif.IFID_Valid, fif.IFID_Instruction, fif.IFID_PCPlus4);
    end
    n_tests++; if (fif.FetchCount !== 32'd8) begin n_fail++; $display("FAIL br_count got %0d want 8", fif.FetchCount); end
    drive(0, 0, 0, 0, 0); tick();
    n_tests++; if (fif.IFID_PCPlus4 !== 32'h44 || fif.IFID_Valid !== 1'b1) begin
      n_fail++; $display("FAIL br_target_fetch got pc4=%h v=%b want 44 1", fif.IFID_PCPlus4, fif.IFID_Valid);
    end
  endtask

  task automatic test_jump_priority();
    drive(0, 1, 32'h80, 1, 32'h100); tick();
    n_tests++; if (fif.PCResult !== 32'h100) begin n_fail++; $display("FAIL jmp_prio_pc got %h want 100", fif.PCResult); end
    drive(0, 0, 0, 0, 0); tick();
    drive(1, 1, 32'h80, 1, 32'h300); tick();
    n_tests++; if (fif.PCResult !== 32'h104 || fif.IFID_Valid !== 1'b1 || fif.IFID_PCPlus4 !== 32'h104) begin
      n_fail++; $display("FAIL stall_over_jmp got pc=%h v=%b pc4=%h want 104 1 104", fif.PCResult, fif.IFID_Valid, fif.IFID_PCPlus4);
    end
  endtask

  task automatic test_align();
    hard_reset();
    drive(0, 0, 0, 1, 32'h103); tick();
    n_tests++; if (fif.PCResult !== 32'h100 || fif.AlignErr !== 1'b1) begin
      n_fail++; $display("FAIL align_jmp got pc=%h ae=%b want 100 1", fif.PCResult, fif.AlignErr);
    end
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 0); tick(); end
    n_tests++; if (fif.AlignErr !== 1'b1) begin n_fail++; $display("FAIL align_sticky got %b want 1", fif.AlignErr); end
    drive(1, 1, 32'h7, 0, 0); tick();
    hard_reset();
    n_tests++; if (fif.AlignErr !== 1'b0) begin n_fail++; $display("FAIL align_clear got %b want 0", fif.AlignErr); end
  endtask

  task automatic test_wrap();
    hard_reset();
    drive(0, 0, 0, 1, 32'hFFFF_FFFC); tick();
    n_tests++; if (fif.PCResult !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup_pc got %h want fffffffc", fif.PCResult); end
    drive(0, 0, 0, 0, 0); tick();
    n_tests++; if (fif.PCResult !== 32'h0 || fif.IFID_PCPlus4 !== 32'h0 || fif.IFID_Valid !== 1'b1) begin
      n_fail++; $display("FAIL pc_wrap got pc=%h pc4=%h v=%b want 0 0 1", fif.PCResult, fif.IFID_PCPlus4, fif.IFID_Valid);
    end
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    n_tests++; if (fif.FetchCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_preload got %h want ffffffff", fif.FetchCount); end
    drive(0, 0, 0, 0, 0); tick();
    n_tests++; if (fif.FetchCount !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap got %h want 0", fif.FetchCount); end
  endtask

  task automatic test_random();
    int r;
    logic [31:0] bt, jt;
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++; if (fif.PCResult !== 32'h0 || fif.IFID_Valid !== 1'b0 || fif.FetchCount !== 32'h0 || fif.AlignErr !== 1'b0) begin
          n_fail++; $display("FAIL rand_reset cyc %0d got pc=%h v=%b cnt=%h ae=%b want 0", i, fif.PCResult, fif.IFID_Valid, fif.FetchCount, fif.AlignErr);
        end
        rst = 1'b0;
      end
      bt = $urandom; jt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, bt, $urandom_range(0, 7) == 0, jt);
      tick();
      n_tests++;
      if (fif.PCResult !== m_pc || fif.IFID_Instruction !== m_instr || fif.IFID_PCPlus4 !== m_pc4 ||
          fif.IFID_Valid !== m_valid || fif.AlignErr !== m_align || fif.FetchCount !== m_cnt) begin
        n_fail++;
        $display("FAIL rand cyc %0d got pc=%h ins=%h pc4=%h v=%b ae=%b cnt=%h want pc=%h ins=%h pc4=%h v=%b ae=%b cnt=%h",
                 i, fif.PCResult, fif.IFID_Instruction, fif.IFID_PCPlus4, fif.IFID_Valid, fif.AlignErr, fif.FetchCount,
                 m_pc, m_instr, m_pc4, m_valid, m_align, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch();
    test_jump_priority();
    test_align();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
